fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 27 ++
 rtl/fifo_rd_obuf.sv | 85 ++++++++
 rtl/fifo_rd_stream.sv | 114 +++++++++++
 tb/tb_fifo_rd_stream.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared constants and types for the FIFO read-side streaming stage.
//   BUF_DEPTH : entries in the output skid queue
//   BUF_AW    : width of head/tail pointers and of the occupancy count
//   cnt16_t   : 16-bit counter type (beat position, packet count)
//   buf_ptr_t : pointer / occupancy type sized by BUF_AW
//   ptr_inc() : circular increment of a queue pointer over BUF_DEPTH slots
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int BUF_AW    = 2;

  typedef logic [15:0]       cnt16_t;
  typedef logic [BUF_AW-1:0] buf_ptr_t;

  // The queue depth is not a power of two, so pointers wrap explicitly
  // from the last slot back to zero instead of relying on overflow.
  function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
    if (p == buf_ptr_t'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + buf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// -----------------------------------------------------------------------------
// fifo_rd_obuf
// Three-entry circular output queue sitting between the FIFO read port and
// the AXI4-Stream master. Words enter through 'capture' and leave through
// 'pop'; the head entry is always presented on 'rd_data'.
//
// Ports
//   clk      in   clock
//   rstn     in   asynchronous active-low reset; empties the queue
//   capture  in   write wr_data at tail this cycle
//   wr_data  in   B-bit word to store
//   pop      in   retire the head entry this cycle
//   rd_data  out  B-bit word at head
//   empty    out  queue holds no words
//   level    out  number of words held (0..BUF_DEPTH)
// -----------------------------------------------------------------------------
module fifo_rd_obuf
  import fifo_rd_pkg::*;
#(
  parameter int B = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           capture,
  input  logic [B-1:0]   wr_data,
  input  logic           pop,
  output logic [B-1:0]   rd_data,
  output logic           empty,
  output logic [BUF_AW-1:0] level
);

  localparam buf_ptr_t FULL_LEVEL = buf_ptr_t'(BUF_DEPTH);

  buf_ptr_t     head;
  buf_ptr_t     tail;
  buf_ptr_t     occ;
  logic [B-1:0] mem [BUF_DEPTH];

  // Storage array; contents need no reset because 'occ' alone decides
  // which slots hold meaningful data.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous capture and pop moves
  // both pointers and leaves the occupancy where it was.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (capture) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + buf_ptr_t'(1);
        2'b01:   occ <= occ - buf_ptr_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head entry is presented directly from storage; no bypass from wr_data,
  // so a word captured into an empty queue shows up one cycle later.
  always_comb begin
    rd_data = mem[head];
    empty   = (occ == '0);
    level   = occ;
  end

  // The upstream issue rule reserves a slot for every in-flight read, so the
  // queue can never be written while full nor popped while empty.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(capture && (occ == FULL_LEVEL)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
    !(pop && (occ == '0)));

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Drains an upstream FIFO with one cycle of read latency and presents the
// words as an AXI4-Stream master at one beat per cycle. The stream is framed
// into fixed L-beat packets with tlast, and completed packets are counted.
// The FIFO read strobe depends only on registered state, 'en', 'fifo_empty'
// and reset, never on m_axis_tready.
//
// Parameters
//   B  data width (matches the upstream FIFO)
//   L  packet length in beats, 1..65535
//
// Ports
//   clk            in   clock
//   rstn           in   asynchronous active-low reset
//   en             in   allow new FIFO reads
//   fifo_empty     in   upstream FIFO empty flag
//   fifo_rd_en     out  upstream FIFO read strobe
//   fifo_dout      in   upstream read data, valid the cycle after a read
//   m_axis_tdata   out  stream data
//   m_axis_tvalid  out  stream valid
//   m_axis_tlast   out  last beat of a packet
//   m_axis_tready  in   stream ready
//   pkt_cnt        out  completed packet count, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int B = 16,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [B-1:0] fifo_dout,
  output logic [B-1:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready,
  output logic [15:0]  pkt_cnt
);

  localparam cnt16_t LAST_BEAT = cnt16_t'(L - 1);

  logic        inflight;
  logic        pop;
  logic        buf_empty;
  buf_ptr_t    level;
  logic [2:0]  committed;
  cnt16_t      beat;
  cnt16_t      pkt_cnt_q;

  // Output queue holding captured words until the sink accepts them.
  fifo_rd_obuf #(
    .B (B)
  ) u_obuf (
    .clk     (clk),
    .rstn    (rstn),
    .capture (inflight),
    .wr_data (fifo_dout),
    .pop     (pop),
    .rd_data (m_axis_tdata),
    .empty   (buf_empty),
    .level   (level)
  );

  // Issue a read only when a queue slot is guaranteed for the returning word:
  // words already held plus the one still in flight must leave room. Gating
  // with rstn keeps the strobe low for the whole reset window, matching the
  // upstream FIFO which shares this reset.
  always_comb begin
    committed  = {1'b0, level} + {2'b00, inflight};
    fifo_rd_en = rstn & en & ~fifo_empty & (committed < 3'(BUF_DEPTH));
  end

  // One-cycle read latency tracker: a strobe this cycle means fifo_dout
  // carries the word next cycle, which is then captured into the queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Stream handshake. Valid comes purely from queue occupancy, so tdata and
  // tlast hold steady while the sink stalls.
  always_comb begin
    m_axis_tvalid = ~buf_empty;
    pop           = m_axis_tvalid & m_axis_tready;
    m_axis_tlast  = (beat == LAST_BEAT) & m_axis_tvalid;
    pkt_cnt       = pkt_cnt_q;
  end

  // Packet framing: beat position advances on every accepted beat and
  // returns to zero after the last one; each accepted last beat completes
  // a packet. With L = 1 the position stays at zero and every beat is last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat      <= '0;
      pkt_cnt_q <= '0;
    end else if (pop) begin
      if (beat == LAST_BEAT) begin
        beat      <= '0;
        pkt_cnt_q <= pkt_cnt_q + cnt16_t'(1);
      end else begin
        beat      <= beat + cnt16_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Self-checking bench for fifo_rd_stream. A queue-based model of the upstream
// FIFO feeds the DUT; a transaction-level reference (expected word queue,
// one pending read, total beats accepted) predicts every output each cycle.
// A second instance with L = 1 is run through a 16-bit packet-count wrap.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int B = 16;
  localparam int L = 8;
  localparam int WRAP_WORDS = 65537;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [B-1:0] fifo_dout;
  logic [B-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [15:0]  pkt_cnt;

  logic         en2;
  logic         fifo_empty2;
  logic         fifo_rd_en2;
  logic [B-1:0] fifo_dout2;
  logic [B-1:0] tdata2;
  logic         tvalid2;
  logic         tlast2;
  logic         tready2;
  logic [15:0]  pkt_cnt2;

  fifo_rd_stream #(.B(B), .L(L)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt)
  );

  fifo_rd_stream #(.B(B), .L(1)) dut_wrap (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en2),
    .fifo_empty    (fifo_empty2),
    .fifo_rd_en    (fifo_rd_en2),
    .fifo_dout     (fifo_dout2),
    .m_axis_tdata  (tdata2),
    .m_axis_tvalid (tvalid2),
    .m_axis_tlast  (tlast2),
    .m_axis_tready (tready2),
    .pkt_cnt       (pkt_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO contents and the reference model state.
  logic [B-1:0] fq[$];
  logic [B-1:0] mq[$];
  bit           m_pend;
  logic [B-1:0] m_pend_word;
  int unsigned  m_pops;
  logic [B-1:0] next_word;

  int vectors;
  int miscompares;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushWords(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        fq.push_back(B'($urandom));
      end else begin
        fq.push_back(next_word);
        next_word++;
      end
    end
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks all
  // outputs against the reference, advances the reference across the rising
  // edge, then lets the FIFO model answer a read one cycle later.
  task automatic applyStimulus(input bit en_v, input bit ready_v);
    bit exp_issue;
    bit rd_obs;
    bit exp_pop;
    en            = en_v;
    m_axis_tready = ready_v;
    fifo_empty    = (fq.size() == 0);
    #1;
    exp_issue = en_v && (fq.size() != 0) && ((mq.size() + int'(m_pend)) < 3);
    rd_obs    = fifo_rd_en;
    checkOutput("rd_en", 32'(fifo_rd_en), 32'(exp_issue));
    checkOutput("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("tdata", 32'(m_axis_tdata), 32'(mq[0]));
      checkOutput("tlast", 32'(m_axis_tlast), 32'((m_pops % L) == L - 1));
    end
    checkOutput("pkt_cnt", 32'(pkt_cnt), (m_pops / L) % 65536);
    exp_pop = (mq.size() != 0) && ready_v;
    if (exp_pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (m_pend) mq.push_back(m_pend_word);
    m_pend = exp_issue;
    if (exp_issue) m_pend_word = fq[0];
    @(posedge clk);
    #1;
    if (rd_obs && fq.size() != 0) fifo_dout = fq.pop_front();
    @(negedge clk);
  endtask

  task automatic runCycles(input int n, input bit en_v, input bit ready_v);
    for (int i = 0; i < n; i++) applyStimulus(en_v, ready_v);
  endtask

  // Asynchronous reset in the middle of a cycle; the upstream FIFO shares it.
  task automatic doReset();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    fq.delete();
    mq.delete();
    m_pend = 1'b0;
    m_pops = 0;
    fifo_empty = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int unsigned issued2, pops2, nolast2, bad2;
    logic [B-1:0] gen2, exp2;
    bit rd2;

    vectors = 0;  miscompares = 0;
    rstn = 1'b0;  en = 1'b0;  m_axis_tready = 1'b0;
    fifo_empty = 1'b1;  fifo_dout = '0;
    en2 = 1'b0;  fifo_empty2 = 1'b0;  fifo_dout2 = '0;  tready2 = 1'b1;
    m_pend = 1'b0;  m_pops = 0;  next_word = 16'h0001;

    #1;
    checkOutput("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Streaming: 16 words in order, two packets.
    pushWords(16, 1'b0);
    runCycles(22, 1'b1, 1'b1);
    checkOutput("stream_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Backpressure from the third beat, then release.
    pushWords(10, 1'b0);
    runCycles(4, 1'b1, 1'b1);
    runCycles(6, 1'b1, 1'b0);
    runCycles(15, 1'b1, 1'b1);

    // Empty after 5 words, refill a few cycles later.
    pushWords(5, 1'b0);
    runCycles(8, 1'b1, 1'b1);
    runCycles(4, 1'b1, 1'b1);
    pushWords(6, 1'b0);
    runCycles(10, 1'b1, 1'b1);

    // en dropped right after a read issues.
    pushWords(4, 1'b0);
    runCycles(1, 1'b1, 1'b1);
    runCycles(6, 1'b0, 1'b1);
    runCycles(10, 1'b1, 1'b1);

    // Reset with two words buffered, then a fresh packet.
    pushWords(2, 1'b0);
    runCycles(4, 1'b1, 1'b0);
    doReset();
    pushWords(8, 1'b0);
    runCycles(14, 1'b1, 1'b1);
    checkOutput("post_reset_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Randomised traffic, then drain.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) pushWords(int'($urandom_range(3, 1)), 1'b1);
      applyStimulus($urandom_range(9) != 0, $urandom_range(3) != 0);
    end
    runCycles(30, 1'b1, 1'b1);
    checkOutput("drain_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Packet-count wrap on the L = 1 instance with an always-full source.
    issued2 = 0;  pops2 = 0;  nolast2 = 0;  bad2 = 0;
    gen2 = '0;  exp2 = '0;
    for (int c = 0; c < 66000 && pops2 < WRAP_WORDS; c++) begin
      en2 = (issued2 < WRAP_WORDS);
      #1;
      rd2 = fifo_rd_en2;
      if (tvalid2) begin
        pops2++;
        if (!tlast2) nolast2++;
        if (tdata2 !== exp2) bad2++;
        exp2++;
      end
      if (rd2) issued2++;
      @(posedge clk);
      #1;
      if (rd2) begin
        fifo_dout2 = gen2;
        gen2++;
      end
      @(negedge clk);
    end
    en2 = 1'b0;
    #1;
    checkOutput("wrap_beats", pops2, WRAP_WORDS);
    checkOutput("wrap_missing_tlast", nolast2, 32'd0);
    checkOutput("wrap_data_errors", bad2, 32'd0);
    checkOutput("wrap_pkt_cnt", 32'(pkt_cnt2), 32'd1);
    checkOutput("wrap_idle_tvalid", 32'(tvalid2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
